mem_access_release: RTL and testbench
=====================================

# mem_access_release

Release stage directly downstream of the memory-access FIFO. Watches the FIFO head (RAM bank index, issue timestamp, due timestamp, address), holds it until the global cycle counter reaches its due time, then pops it into a one-entry output register. That register is presented to the RAM-response path with a valid/ready handshake, tagged with measured latency and a late flag.

## Interface
Parameters:
- `ADDR_W`, 32: width of head/response address (matches `SIZE_ADDR`).
- `RAM_LOG`, 5: bank index width.
- `CNT_W`, 16: timestamp/counter width.
- `LATE_THRESH`, 4: cycles past due beyond which a release is flagged late.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall_i`  in  1  global pipeline stall; freezes capture, pop and stats.
- `now_count`  in  CNT_W  free-running global cycle counter (same source as FIFO `count`).
- `head_valid`  in  1  FIFO holds at least one entry.
- `head_ram_addr`  in  RAM_LOG  bank index at FIFO head.
- `head_in_time`  in  CNT_W  head issue timestamp.
- `head_out_time`  in  CNT_W  head due timestamp.
- `head_addr`  in  ADDR_W  head address.
- `pop`  out  1  one-cycle pulse; FIFO advances head (drives FIFO `o`).
- `resp_valid`  out  1  output register full.
- `resp_ready`  in  1  consumer accepts.
- `resp_ram_addr`  out  RAM_LOG  registered bank index.
- `resp_addr`  out  ADDR_W  registered address.
- `resp_latency`  out  CNT_W  `now_count - head_in_time` at capture, mod 2^CNT_W.
- `resp_late`  out  1  release occurred more than LATE_THRESH cycles after due.
- `stats_clear`  in  1  zeroes statistics counters.
- `stat_retired`  out  32  accepted responses.
- `stat_late`  out  CNT_W  accepted responses with `resp_late`.
- `stat_max_lat`  out  CNT_W  largest `resp_latency` accepted.

## Operation
- FSM states: IDLE (no head, reg empty), WAIT (head present, not due, reg empty), HOLD (reg full).
- Due test, wrap-safe: `slack = now_count - head_out_time` (CNT_W bits); due when MSB of slack is 0. Entries must not be more than 2^(CNT_W-1) cycles from due.
- Capture condition `cap = head_valid & due & ~stall_i & (~resp_valid | resp_ready)`.
- `pop = cap` (combinational). On the edge: register loads head fields, `resp_latency`, `resp_late = (slack > LATE_THRESH)`; `resp_valid` ← 1.
- Accept without capture (`resp_valid & resp_ready & ~cap`): `resp_valid` ← 0.
- Simultaneous accept + capture: register reloads, `resp_valid` stays 1 (back-to-back, 1 entry/cycle).
- Transitions: IDLE→WAIT on `head_valid` & not due; any→HOLD on cap; HOLD→IDLE/WAIT on accept without cap.
- `stall_i` high: no pop, no capture, register and stats hold; `resp_valid` held, and accept still clears `resp_valid` (consumer not stalled by this block).
- `head_valid` low: no pop regardless of due.
- `resp_*` payload stable while `resp_valid & ~resp_ready`.

## Timing
- Reset values: `pop`=0, `resp_valid`=0, `resp_ram_addr`=0, `resp_addr`=0, `resp_latency`=0, `resp_late`=0, all stats 0, FSM IDLE.
- Reset mid-operation discards the held entry; entry already popped is lost (FIFO resets in same cycle).
- Latency: entry due at cycle T with empty register → `pop` at T, `resp_valid` at T+1.
- FIFO read is combinational; after `pop` at T, new head visible at T+1 and may pop at T+1.
- Stats update on accept edge; `stats_clear` wins over same-cycle increment. `stat_retired` wraps at 2^32, `stat_late` saturates at all-ones.

## Configuration
- `MEM_RELEASE_STATS_EN` defined: statistics counters and `stats_clear` logic built.
- Undefined: `stat_retired`, `stat_late`, `stat_max_lat` tied 0, `stats_clear` ignored; datapath unchanged.

## Test plan
- Head in_time=100, out_time=110, `resp_ready`=1; sweep now_count 100..112 → `pop` only at now=110, `resp_valid` at 111 with latency=10, late=0.
- Wrap: out_time=0x0003, now from 0xFFFE → no pop until now=0x0003; at 0xFFFE slack MSB=1 (not due).
- Three due entries, `resp_ready`=1 → pops on 3 consecutive cycles, 3 consecutive `resp_valid` beats, payloads in order.
- `resp_ready`=0 for 5 cycles with due head → single pop, payload stable, second pop same cycle `resp_ready` returns.
- Head due at now=200, release at 206 (stall_i high 200–205) → no pop during stall, late=1, stat_late=1 (stats build).
- Reset asserted while `resp_valid`=1 → next cycle `resp_valid`=0, stats 0, no pop while `head_valid`=0.

Source files
------------

// File: rtl/mem_access_release.sv
// Release stage after the memory-access FIFO: holds the head until due, then pops it into a
// one-entry valid/ready output register. Define MEM_RELEASE_STATS_EN to build the statistics counters.
module mem_access_release #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned RAM_LOG     = 5,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LATE_THRESH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic [CNT_W-1:0]   now_count,
  input  logic               head_valid,
  input  logic [RAM_LOG-1:0] head_ram_addr,
  input  logic [CNT_W-1:0]   head_in_time,
  input  logic [CNT_W-1:0]   head_out_time,
  input  logic [ADDR_W-1:0]  head_addr,
  output logic               pop,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [RAM_LOG-1:0] resp_ram_addr,
  output logic [ADDR_W-1:0]  resp_addr,
  output logic [CNT_W-1:0]   resp_latency,
  output logic               resp_late,
  input  logic               stats_clear,
  output logic [31:0]        stat_retired,
  output logic [CNT_W-1:0]   stat_late,
  output logic [CNT_W-1:0]   stat_max_lat
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] slack;
  logic             due, cap, accept;

  // Wrap-safe due test: head is due once now has reached out_time (slack non-negative).
  always_comb begin
    slack  = now_count - head_out_time;
    due    = ~slack[CNT_W-1];
    accept = resp_valid & resp_ready;
    cap    = ~reset & head_valid & due & ~stall_i & (~resp_valid | resp_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, WAIT: begin
        if (cap)             state_d = HOLD;
        else if (head_valid) state_d = WAIT;
        else                 state_d = IDLE;
      end
      HOLD: begin
        if (cap)         state_d = HOLD;
        else if (accept) state_d = head_valid ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    resp_valid = 1'b0;
    pop        = cap;
    resp_valid = (state_q == HOLD);
  end

  // Output payload only changes on capture, so it is stable under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_ram_addr <= '0;
      resp_addr     <= '0;
      resp_latency  <= '0;
      resp_late     <= 1'b0;
    end else if (cap) begin
      resp_ram_addr <= head_ram_addr;
      resp_addr     <= head_addr;
      resp_latency  <= now_count - head_in_time;
      resp_late     <= (slack > CNT_W'(LATE_THRESH));
    end
  end

`ifdef MEM_RELEASE_STATS_EN
  // Statistics track accepted beats; clear overrides a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      stat_retired <= '0;
      stat_late    <= '0;
      stat_max_lat <= '0;
    end else if (accept && !stall_i) begin
      stat_retired <= stat_retired + 32'd1;
      if (resp_late && (stat_late != '1)) stat_late <= stat_late + CNT_W'(1);
      if (resp_latency > stat_max_lat)    stat_max_lat <= resp_latency;
    end
  end
`else
  logic unused_stats_clear;
  assign unused_stats_clear = stats_clear;
  assign stat_retired = '0;
  assign stat_late    = '0;
  assign stat_max_lat = '0;
`endif

endmodule

// File: tb/tb_mem_access_release.sv
// Directed bench for mem_access_release: due sweep, wrap, back-to-back, backpressure, stall, reset.
module tb_mem_access_release;

  logic        clk = 1'b0;
  logic        reset, stall_i, head_valid, resp_ready, stats_clear;
  logic [15:0] now_count, head_in_time, head_out_time;
  logic [4:0]  head_ram_addr;
  logic [31:0] head_addr;
  logic        pop, resp_valid, resp_late;
  logic [4:0]  resp_ram_addr;
  logic [31:0] resp_addr;
  logic [15:0] resp_latency, stat_late, stat_max_lat;
  logic [31:0] stat_retired;

  int nvec = 0;
  int nerr = 0;

  mem_access_release dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .now_count(now_count),
    .head_valid(head_valid), .head_ram_addr(head_ram_addr), .head_in_time(head_in_time),
    .head_out_time(head_out_time), .head_addr(head_addr), .pop(pop),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ram_addr(resp_ram_addr),
    .resp_addr(resp_addr), .resp_latency(resp_latency), .resp_late(resp_late),
    .stats_clear(stats_clear), .stat_retired(stat_retired), .stat_late(stat_late),
    .stat_max_lat(stat_max_lat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input logic [4:0] ram, input logic [15:0] tin, input logic [15:0] tout,
                          input logic [31:0] addr);
    head_valid    = 1'b1;
    head_ram_addr = ram;
    head_in_time  = tin;
    head_out_time = tout;
    head_addr     = addr;
  endtask

  task automatic chk_stats(input string tag, input logic [31:0] ret, input logic [15:0] late,
                           input logic [15:0] maxl);
`ifdef MEM_RELEASE_STATS_EN
    chk({tag, "_retired"}, stat_retired, ret);
    chk({tag, "_late"},    stat_late,    late);
    chk({tag, "_maxlat"},  stat_max_lat, maxl);
`else
    chk({tag, "_retired"}, stat_retired, 0);
    chk({tag, "_late"},    stat_late,    0);
    chk({tag, "_maxlat"},  stat_max_lat, 0);
`endif
  endtask

  logic [31:0] addrs [3];

  initial begin
    reset = 1'b1; stall_i = 1'b0; head_valid = 1'b0; resp_ready = 1'b1; stats_clear = 1'b0;
    now_count = '0; head_in_time = '0; head_out_time = '0; head_ram_addr = '0; head_addr = '0;
    addrs[0] = 32'hA000_0000; addrs[1] = 32'hA000_0004; addrs[2] = 32'hA000_0008;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rst_valid", resp_valid, 0);
    chk("rst_pop", pop, 0);
    chk("rst_addr", resp_addr, 0);
    chk("rst_lat", resp_latency, 0);
    chk("rst_late", resp_late, 0);
    chk_stats("rst", 0, 0, 0);

    // Due sweep: in=100, out=110
    set_head(5'd3, 16'd100, 16'd110, 32'hDEAD_BEEF);
    for (int n = 100; n <= 112; n++) begin
      now_count = 16'(n);
      if (n == 111) head_valid = 1'b0;
      #1;
      chk($sformatf("sweep_pop_%0d", n), pop, (n == 110));
      chk($sformatf("sweep_valid_%0d", n), resp_valid, (n == 111));
      if (n == 111) begin
        chk("sweep_lat", resp_latency, 10);
        chk("sweep_late", resp_late, 0);
        chk("sweep_addr", resp_addr, 32'hDEAD_BEEF);
        chk("sweep_ram", resp_ram_addr, 3);
      end
      cyc();
    end

    // Counter wrap: out=0x0003 reached from 0xFFFE
    set_head(5'd7, 16'hFFF0, 16'h0003, 32'h0000_1234);
    for (int i = 0; i < 7; i++) begin
      now_count = 16'hFFFE + 16'(i);
      if (i == 6) head_valid = 1'b0;
      #1;
      chk($sformatf("wrap_pop_%0d", i), pop, (i == 5));
      if (i == 6) begin
        chk("wrap_valid", resp_valid, 1);
        chk("wrap_lat", resp_latency, 16'h0013);
        chk("wrap_addr", resp_addr, 32'h0000_1234);
      end
      cyc();
    end

    // Three due entries back-to-back
    for (int k = 0; k <= 3; k++) begin
      now_count = 16'h0020 + 16'(k);
      if (k < 3) set_head(5'(k + 1), 16'h0018, 16'h001F, addrs[k]);
      else       head_valid = 1'b0;
      #1;
      chk($sformatf("b2b_pop_%0d", k), pop, (k < 3));
      chk($sformatf("b2b_valid_%0d", k), resp_valid, (k > 0));
      if (k > 0) begin
        chk($sformatf("b2b_addr_%0d", k), resp_addr, addrs[k-1]);
        chk($sformatf("b2b_lat_%0d", k), resp_latency, 8 + k - 1);
        chk($sformatf("b2b_ram_%0d", k), resp_ram_addr, k);
      end
      cyc();
    end
    #1;
    chk("b2b_drain", resp_valid, 0);

    // Backpressure: ready low 5 cycles, second pop when ready returns
    now_count = 16'h0040;
    set_head(5'd9, 16'h0030, 16'h003F, 32'hB0B0_0000);
    #1;
    chk("bp_pop0", pop, 1);
    cyc();
    set_head(5'd10, 16'h0030, 16'h003F, 32'hB0B0_0001);
    resp_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk($sformatf("bp_hold_pop_%0d", s), pop, 0);
      chk($sformatf("bp_hold_valid_%0d", s), resp_valid, 1);
      chk($sformatf("bp_hold_addr_%0d", s), resp_addr, 32'hB0B0_0000);
      cyc();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_pop1", pop, 1);
    chk("bp_addr0", resp_addr, 32'hB0B0_0000);
    cyc();
    head_valid = 1'b0;
    #1;
    chk("bp_valid1", resp_valid, 1);
    chk("bp_addr1", resp_addr, 32'hB0B0_0001);
    chk("bp_lat1", resp_latency, 16);
    cyc();
    #1;
    chk("bp_drain", resp_valid, 0);

    // Stall over the due window makes the release late
    set_head(5'd2, 16'd190, 16'd200, 32'h5555_AAAA);
    for (int n = 198; n <= 207; n++) begin
      now_count = 16'(n);
      stall_i = (n >= 200 && n <= 205);
      if (n == 207) head_valid = 1'b0;
      #1;
      chk($sformatf("stall_pop_%0d", n), pop, (n == 206));
      if (n == 207) begin
        chk("stall_valid", resp_valid, 1);
        chk("stall_late", resp_late, 1);
        chk("stall_lat", resp_latency, 16);
      end
      cyc();
    end
    chk_stats("stats", 8, 1, 19);

    stats_clear = 1'b1;
    cyc();
    stats_clear = 1'b0;
    #1;
    chk_stats("clear", 0, 0, 0);

    // Reset with a held entry
    now_count = 16'h0060;
    resp_ready = 1'b0;
    set_head(5'd4, 16'h0050, 16'h0050, 32'hCAFE_0000);
    #1;
    chk("rst2_pop", pop, 1);
    cyc();
    head_valid = 1'b0;
    #1;
    chk("rst2_held", resp_valid, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    resp_ready = 1'b1;
    head_out_time = 16'h0000;
    #1;
    chk("rst2_valid", resp_valid, 0);
    chk("rst2_addr", resp_addr, 0);
    chk("rst2_nohead_pop", pop, 0);
    chk_stats("rst2", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
